// File: rtl/sm_hex_pkg.sv
// rtl/sm_hex_pkg.sv - segment bit order and active-low hex glyph patterns
// Bit order of every pattern is {g,f,e,d,c,b,a}; a 0 lights the segment.
package sm_hex_pkg;

  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } segBit_e;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A_H = 7'b0001000;
  localparam logic [6:0] SEG_B_H = 7'b0000011;
  localparam logic [6:0] SEG_C_H = 7'b1000110;
  localparam logic [6:0] SEG_D_H = 7'b0100001;
  localparam logic [6:0] SEG_E_H = 7'b0000110;
  localparam logic [6:0] SEG_F_H = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A_H;
      4'hB:    return SEG_B_H;
      4'hC:    return SEG_C_H;
      4'hD:    return SEG_D_H;
      4'hE:    return SEG_E_H;
      default: return SEG_F_H;
    endcase
  endfunction

endpackage

// File: rtl/sm_hex_to_seg.sv
// rtl/sm_hex_to_seg.sv - combinational nibble to active-low segment decoder
// A set blank input forces every segment off regardless of the nibble.
module sm_hex_to_seg
  import sm_hex_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] segments
);

  always_comb begin
    segments = blank ? SEG_OFF : hexToSeg(nibble);
  end

endmodule

// File: rtl/sm_hex_display_scan.sv
// rtl/sm_hex_display_scan.sv - multiplexed hex display scanner with tear-free update and PWM
// Optional leading-zero blanking is built when SM_HEX_LZB_EN is defined.
module sm_hex_display_scan
  import sm_hex_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int PRESCALE_W = 16
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  load,
  input  logic [3:0]            brightness,
  input  logic                  blank_lz,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [PRESCALE_W-1:0] pcnt;
  logic [IDX_W-1:0]      idx;
  logic [4*DIGITS-1:0]   shadowNumber;
  logic [4*DIGITS-1:0]   activeNumber;
  logic [DIGITS-1:0]     shadowDots;
  logic [DIGITS-1:0]     activeDots;
  logic                  slotEnd;
  logic                  boundary;
  logic                  digitOn;
  logic                  blankDigit;
  logic                  curDot;
  logic [3:0]            curNibble;
  logic [6:0]            curSegments;

  assign slotEnd  = &pcnt;
  assign boundary = slotEnd && (idx == LAST_IDX);
  // PWM compares the top prescaler nibble, so level 0 still lights 1/16 of the slot
  assign digitOn  = pcnt[PRESCALE_W-1 -: 4] <= brightness;

  always_comb begin
    curNibble = 4'h0;
    curDot    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        curNibble = activeNumber[4*i +: 4];
        curDot    = activeDots[i];
      end
    end
  end

`ifdef SM_HEX_LZB_EN
  // leadZero[i]: active nibbles DIGITS-1 down to i are all zero
  logic [DIGITS-1:0] leadZero;

  always_comb begin
    leadZero = '0;
    leadZero[DIGITS-1] = (activeNumber[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      leadZero[i] = leadZero[i+1] && (activeNumber[4*i +: 4] == 4'h0);
    end
  end

  assign blankDigit = blank_lz && (idx != '0) && leadZero[idx];
`else
  logic unusedBlankLz;
  assign unusedBlankLz = blank_lz;
  assign blankDigit    = 1'b0;
`endif

  sm_hex_to_seg decoder (
    .nibble   (curNibble),
    .blank    (blankDigit),
    .segments (curSegments)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt           <= '0;
      idx            <= '0;
      shadowNumber   <= '0;
      shadowDots     <= '0;
      activeNumber   <= '0;
      activeDots     <= '0;
      seven_segments <= SEG_OFF;
      dot            <= 1'b1;
      anodes         <= '1;
      frame          <= 1'b0;
    end else begin
      pcnt <= pcnt + 1'b1;
      if (slotEnd) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (load) begin
        shadowNumber <= number;
        shadowDots   <= dots;
      end
      // non-blocking copy takes the pre-load shadow when load hits the boundary
      if (boundary) begin
        activeNumber <= shadowNumber;
        activeDots   <= shadowDots;
      end
      frame <= boundary;
      if (digitOn) begin
        seven_segments <= curSegments;
        dot            <= ~curDot;
        anodes         <= ~(DIGITS'(1) << idx);
      end else begin
        seven_segments <= SEG_OFF;
        dot            <= 1'b1;
        anodes         <= '1;
      end
    end
  end

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// tb/tb_sm_hex_display_scan.sv - randomized bench with reference model for sm_hex_display_scan
// Define SM_HEX_LZB_EN for both bench and RTL to check the blanking build.
module tb_sm_hex_display_scan;

  logic        clk;
  logic        rst;
  logic [15:0] number;
  logic [3:0]  dots;
  logic        load;
  logic [3:0]  brightness;
  logic        blank_lz;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [3:0]  anodes;
  logic        frame;

  int total;
  int bad;

  int          mCyc;
  logic [15:0] mShNum;
  logic [15:0] mActNum;
  logic [3:0]  mShDots;
  logic [3:0]  mActDots;
  logic [6:0]  expSeg;
  logic        expDot;
  logic [3:0]  expAn;
  logic        expFrame;

  logic [6:0] segTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  sm_hex_display_scan #(.DIGITS(4), .PRESCALE_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .number         (number),
    .dots           (dots),
    .load           (load),
    .brightness     (brightness),
    .blank_lz       (blank_lz),
    .seven_segments (seven_segments),
    .dot            (dot),
    .anodes         (anodes),
    .frame          (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position in the scan is derived from the cycle count since reset.
  task automatic step();
    int          p;
    int          d;
    logic        bnd;
    logic        blankIt;
    logic        rstNow;
    logic        loadNow;
    logic [15:0] numNow;
    logic [3:0]  dotsNow;
    rstNow  = rst;
    loadNow = load;
    numNow  = number;
    dotsNow = dots;
    bnd     = 1'b0;
    if (rstNow) begin
      expSeg = 7'h7F; expDot = 1'b1; expAn = 4'hF; expFrame = 1'b0;
    end else begin
      p   = mCyc % 16;
      d   = (mCyc / 16) % 4;
      bnd = (p == 15) && (d == 3);
      blankIt = 1'b0;
`ifdef SM_HEX_LZB_EN
      blankIt = blank_lz && (d > 0) && ((mActNum >> (4 * d)) == 16'd0);
`endif
      expFrame = bnd;
      if (p <= int'(brightness)) begin
        expAn  = ~(4'b0001 << d);
        expSeg = blankIt ? 7'h7F : segTable[4'(mActNum >> (4 * d))];
        expDot = ~mActDots[d];
      end else begin
        expSeg = 7'h7F; expDot = 1'b1; expAn = 4'hF;
      end
    end
    @(posedge clk);
    #1;
    if (rstNow) begin
      mCyc = 0; mShNum = '0; mActNum = '0; mShDots = '0; mActDots = '0;
    end else begin
      if (bnd) begin
        mActNum  = mShNum;
        mActDots = mShDots;
      end
      if (loadNow) begin
        mShNum  = numNow;
        mShDots = dotsNow;
      end
      mCyc++;
    end
  endtask

  task automatic advanceTo(int period, int phase);
    int guard;
    guard = 0;
    while ((mCyc % period) != phase && guard < 300) begin
      step();
      guard++;
    end
  endtask

  task automatic test_reset();
    int frames;
    number = '0; dots = '0; load = 1'b0; brightness = 4'd15; blank_lz = 1'b0;
    rst = 1'b1;
    step();
    step();
    total++;
    if ({seven_segments, dot, anodes, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got seg=%b dot=%b an=%b frame=%b want seg=1111111 dot=1 an=1111 frame=0",
               seven_segments, dot, anodes, frame);
    end
    rst = 1'b0;
    frames = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      if (frame === 1'b1) frames++;
      total++;
      if ({seven_segments, dot, anodes, frame} !== {expSeg, expDot, expAn, expFrame}) begin
        bad++;
        $display("FAIL reset_scan cyc=%0d got seg=%b dot=%b an=%b frame=%b want seg=%b dot=%b an=%b frame=%b",
                 mCyc, seven_segments, dot, anodes, frame, expSeg, expDot, expAn, expFrame);
      end
    end
    total++;
    if (frames != 2) begin
      bad++;
      $display("FAIL frame_count got %0d want 2", frames);
    end
  endtask

  task automatic test_load_pattern();
    number = 16'h12AF; dots = 4'b0100; brightness = 4'd15; load = 1'b1;
    step();
    load = 1'b0;
    advanceTo(64, 0);
    for (int i = 0; i < 64; i++) begin
      step();
      total++;
      if ({seven_segments, dot, anodes, frame} !== {expSeg, expDot, expAn, expFrame}) begin
        bad++;
        $display("FAIL load_scan cyc=%0d got seg=%b dot=%b an=%b frame=%b want seg=%b dot=%b an=%b frame=%b",
                 mCyc, seven_segments, dot, anodes, frame, expSeg, expDot, expAn, expFrame);
      end
      if (i == 0) begin
        total++;
        if ({seven_segments, anodes} !== {7'b0001110, 4'b1110}) begin
          bad++;
          $display("FAIL load_digit0 got seg=%b an=%b want seg=0001110 an=1110", seven_segments, anodes);
        end
      end
      if (i == 32) begin
        total++;
        if ({seven_segments, dot, anodes} !== {7'b0100100, 1'b0, 4'b1011}) begin
          bad++;
          $display("FAIL load_digit2 got seg=%b dot=%b an=%b want seg=0100100 dot=0 an=1011",
                   seven_segments, dot, anodes);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    advanceTo(64, 63);
    number = 16'h5555; dots = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 128; i++) begin
      step();
      total++;
      if ({seven_segments, dot, anodes, frame} !== {expSeg, expDot, expAn, expFrame}) begin
        bad++;
        $display("FAIL b2b_scan cyc=%0d got seg=%b dot=%b an=%b frame=%b want seg=%b dot=%b an=%b frame=%b",
                 mCyc, seven_segments, dot, anodes, frame, expSeg, expDot, expAn, expFrame);
      end
      if (i == 0 || i == 64) begin
        total++;
        if (seven_segments !== ((i == 0) ? 7'b0001110 : 7'b0010010)) begin
          bad++;
          $display("FAIL b2b_frame%0d got seg=%b want %b", i / 64, seven_segments,
                   (i == 0) ? 7'b0001110 : 7'b0010010);
        end
      end
    end
  endtask

  task automatic test_pwm();
    int lowCount;
    for (int lvl = 0; lvl < 2; lvl++) begin
      brightness = (lvl == 0) ? 4'd0 : 4'd7;
      advanceTo(16, 0);
      lowCount = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (anodes !== 4'hF) lowCount++;
        total++;
        if ({seven_segments, dot, anodes, frame} !== {expSeg, expDot, expAn, expFrame}) begin
          bad++;
          $display("FAIL pwm_scan cyc=%0d got seg=%b dot=%b an=%b frame=%b want seg=%b dot=%b an=%b frame=%b",
                   mCyc, seven_segments, dot, anodes, frame, expSeg, expDot, expAn, expFrame);
        end
      end
      total++;
      if (lowCount != int'(brightness) + 1) begin
        bad++;
        $display("FAIL pwm_duty level=%0d got %0d want %0d", brightness, lowCount, int'(brightness) + 1);
      end
    end
    brightness = 4'd15;
  endtask

  task automatic test_lzb();
    logic [6:0] want [4];
    for (int pass = 0; pass < 2; pass++) begin
      number = (pass == 0) ? 16'h0030 : 16'h0000;
      dots = 4'b0000; blank_lz = 1'b1; load = 1'b1;
      step();
      load = 1'b0;
      want[0] = 7'b1000000;
      want[1] = (pass == 0) ? 7'b0110000 : 7'b1000000;
      want[2] = 7'b1000000;
      want[3] = 7'b1000000;
`ifdef SM_HEX_LZB_EN
      want[2] = 7'h7F;
      want[3] = 7'h7F;
      if (pass == 1) want[1] = 7'h7F;
`endif
      advanceTo(64, 0);
      for (int i = 0; i < 64; i++) begin
        step();
        total++;
        if ({seven_segments, dot, anodes, frame} !== {expSeg, expDot, expAn, expFrame}) begin
          bad++;
          $display("FAIL lzb_scan cyc=%0d got seg=%b dot=%b an=%b frame=%b want seg=%b dot=%b an=%b frame=%b",
                   mCyc, seven_segments, dot, anodes, frame, expSeg, expDot, expAn, expFrame);
        end
        if ((i % 16) == 0) begin
          total++;
          if (seven_segments !== want[i / 16]) begin
            bad++;
            $display("FAIL lzb_digit%0d pass=%0d got seg=%b want %b", i / 16, pass, seven_segments, want[i / 16]);
          end
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_mid_reset();
    number = 16'h9E7C; dots = 4'b1111; brightness = 4'd15; load = 1'b1;
    step();
    load = 1'b0;
    advanceTo(64, 37);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({seven_segments, dot, anodes, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL midreset_off got seg=%b dot=%b an=%b frame=%b want seg=1111111 dot=1 an=1111 frame=0",
               seven_segments, dot, anodes, frame);
    end
    for (int i = 0; i < 64; i++) begin
      step();
      total++;
      if ({seven_segments, dot, anodes, frame} !== {expSeg, expDot, expAn, expFrame}) begin
        bad++;
        $display("FAIL midreset_scan cyc=%0d got seg=%b dot=%b an=%b frame=%b want seg=%b dot=%b an=%b frame=%b",
                 mCyc, seven_segments, dot, anodes, frame, expSeg, expDot, expAn, expFrame);
      end
      if (i == 0) begin
        total++;
        if ({seven_segments, dot, anodes} !== {7'b1000000, 1'b1, 4'b1110}) begin
          bad++;
          $display("FAIL midreset_restart got seg=%b dot=%b an=%b want seg=1000000 dot=1 an=1110",
                   seven_segments, dot, anodes);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      load   = ($urandom_range(0, 9) == 0);
      number = 16'($urandom);
      if ($urandom_range(0, 1) == 0) number[15:8] = 8'h00;
      dots   = 4'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      step();
      total++;
      if ({seven_segments, dot, anodes, frame} !== {expSeg, expDot, expAn, expFrame}) begin
        bad++;
        $display("FAIL random_scan cyc=%0d got seg=%b dot=%b an=%b frame=%b want seg=%b dot=%b an=%b frame=%b",
                 mCyc, seven_segments, dot, anodes, frame, expSeg, expDot, expAn, expFrame);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    mCyc = 0; mShNum = '0; mActNum = '0; mShDots = '0; mActDots = '0;
    rst = 1'b1; number = '0; dots = '0; load = 1'b0; brightness = 4'd15; blank_lz = 1'b0;
    test_reset();
    test_load_pattern();
    test_back_to_back();
    test_pwm();
    test_lzb();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
